multi_fetch_stage: RTL and testbench

MULTI_FETCH_STAGE -- requirements
Module: multi_fetch_stage

---
 rtl/mpt_pkg.sv | 61 ++++++
 rtl/mpt_sync_fifo.sv | 62 ++++++
 rtl/multi_fetch_stage.sv | 137 +++++++++++++
 tb/tb_multi_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpt_pkg.sv
// Shared types for the multi-channel fetch stage: transaction layout, buffer entry,
// and the SPA format check applied to every accepted transaction.
package mpt_pkg;

    localparam logic [3:0] BARE_MODE    = 4'd0;
    localparam logic [3:0] SMMPT43_MODE = 4'd1;
    localparam logic [3:0] SMMPT52_MODE = 4'd2;
    localparam logic [3:0] SMMPT64_MODE = 4'd3;

    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        NO_ERROR       = 2'd0,
        NOT_VALID_ADDR = 2'd1
    } page_format_fault_e;

    typedef struct packed {
        logic [3:0]  mode;
        logic [11:0] sdid;
        logic [15:0] ppn;
    } mmpt_t;

    // Alternate views of the 64-bit SPA; the zero fields must be clear in their mode.
    typedef struct packed {
        logic [20:0] zero;
        logic [42:0] addr;
    } spa43_t;

    typedef struct packed {
        logic [11:0] zero;
        logic [51:0] addr;
    } spa52_t;

    typedef struct packed {
        mmpt_t       mmpt;
        logic [63:0] spa;
    } mptw_transaction_t;

    typedef struct packed {
        mptw_transaction_t       data;
        logic [MAX_ID_W-1:0]     id;
        page_format_fault_e      cause;
    } fetch_entry_t;

    function automatic page_format_fault_e spa_format_check(input mmpt_t mmpt, input logic [63:0] spa);
        spa43_t             s43;
        spa52_t             s52;
        page_format_fault_e res;
        s43 = spa43_t'(spa);
        s52 = spa52_t'(spa);
        case (mmpt.mode)
            BARE_MODE:    res = NOT_VALID_ADDR;
            SMMPT43_MODE: res = (s43.zero != '0) ? NOT_VALID_ADDR : NO_ERROR;
            SMMPT52_MODE: res = (s52.zero != '0) ? NOT_VALID_ADDR : NO_ERROR;
            SMMPT64_MODE: res = NO_ERROR;
            default:      res = NOT_VALID_ADDR;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mpt_sync_fifo.sv
// Synchronous FIFO with flush: push/pop take effect at the clock edge, read data is the head entry.
// Push is ignored when full and pop when empty; flush empties the buffer and overrides both.
module mpt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i && !full_o) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/multi_fetch_stage.sv
// Round-robin merge of NUM_CH fetch channels into one buffered, format-checked stream; 1-cycle latency.
// A channel is accepted only when granted, buffer not full, no stall/flush; master side drains freely.
module multi_fetch_stage
    import mpt_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  DEPTH       = 4,
    parameter int  DATA_WIDTH  = $bits(mptw_transaction_t),
    parameter int  DROP_FAULTS = 0,
    localparam int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            fetch_slave_valid,
    output logic [NUM_CH-1:0]            fetch_slave_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fetch_slave_data,
    output logic                         fetch_master_valid,
    input  logic                         fetch_master_ready,
    output logic [DATA_WIDTH-1:0]        fetch_master_data,
    output logic [ID_W-1:0]              fetch_master_id,
    input  logic                         fetch_ctrl_flush,
    input  logic                         fetch_ctrl_stall,
    output page_format_fault_e           exception_cause_o,
    output logic [15:0]                  fault_count_o
);

    localparam int TW = $bits(mptw_transaction_t);
    localparam int CW = $bits(page_format_fault_e);
    localparam int EW = DATA_WIDTH + ID_W + CW;

    logic [ID_W-1:0]       rr_q, rr_d;
    logic [15:0]           fault_cnt_q, fault_cnt_d;
    logic                  alive_q;
    logic                  gnt_vld;
    logic [ID_W-1:0]       gnt_idx;
    int                    cand;
    logic [DATA_WIDTH-1:0] gnt_dat;
    mptw_transaction_t     gnt_txn;
    page_format_fault_e    gnt_cause;
    logic                  gnt_fault;
    logic                  accept_ok;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  buf_full;
    logic                  buf_empty;
    logic [EW-1:0]         head_raw;
    logic [DATA_WIDTH-1:0] head_dat;
    logic [ID_W-1:0]       head_id;
    logic [CW-1:0]         head_cause;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(rr_q) + i) % NUM_CH;
            if (!gnt_vld && fetch_slave_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(cand);
            end
        end
    end

    assign gnt_dat = fetch_slave_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    if (DATA_WIDTH == TW) begin : g_txn_eq
        assign gnt_txn = gnt_dat;
    end else if (DATA_WIDTH > TW) begin : g_txn_trunc
        assign gnt_txn = gnt_dat[TW-1:0];
    end else begin : g_txn_pad
        assign gnt_txn = {{(TW-DATA_WIDTH){1'b0}}, gnt_dat};
    end

    assign gnt_cause = spa_format_check(gnt_txn.mmpt, gnt_txn.spa);
    assign gnt_fault = (gnt_cause != NO_ERROR);

    // Full blocks acceptance outright, even when the head is popped this same cycle.
    assign accept_ok = alive_q && !buf_full && !fetch_ctrl_stall && !fetch_ctrl_flush;
    assign accept    = accept_ok && gnt_vld;
    assign push      = accept && !((DROP_FAULTS != 0) && gnt_fault);
    assign pop       = fetch_master_valid && fetch_master_ready && !fetch_ctrl_flush;

    always_comb begin
        fetch_slave_ready = '0;
        if (accept) begin
            fetch_slave_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_d        = rr_q;
        fault_cnt_d = fault_cnt_q;
        if (accept) begin
            rr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
            if (gnt_fault && (fault_cnt_q != 16'hFFFF)) begin
                fault_cnt_d = fault_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            fault_cnt_q <= '0;
            alive_q     <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            fault_cnt_q <= fault_cnt_d;
            alive_q     <= 1'b1;
        end
    end

    mpt_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (fetch_ctrl_flush),
        .push_i  (push),
        .wdata_i ({gnt_dat, gnt_idx, CW'(gnt_cause)}),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // Head fields are masked when empty so stale storage never leaks onto the outputs.
    assign {head_dat, head_id, head_cause} = head_raw;
    assign fetch_master_valid = !buf_empty;
    assign fetch_master_data  = fetch_master_valid ? head_dat : '0;
    assign fetch_master_id    = fetch_master_valid ? head_id : '0;
    assign exception_cause_o  = fetch_master_valid ? page_format_fault_e'(head_cause) : NO_ERROR;
    assign fault_count_o      = fault_cnt_q;

endmodule

// File: tb/tb_multi_fetch_stage.sv
// Directed bench: stimulus pushes expected entries into a scoreboard queue, a monitor pops on output handshakes.
module tb_multi_fetch_stage;
    import mpt_pkg::*;

    localparam int NCH = 2;
    localparam int DW  = $bits(mptw_transaction_t);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NCH-1:0]     s_vld;
    logic [NCH-1:0]     s_rdy, d_s_rdy;
    logic [NCH*DW-1:0]  s_dat;
    logic               m_rdy;
    logic               m_vld, d_m_vld;
    logic [DW-1:0]      m_dat, d_m_dat;
    logic [0:0]         m_id, d_m_id;
    logic               flush, stall;
    page_format_fault_e cause, d_cause;
    logic [15:0]        fcnt, d_fcnt;

    int           n_vec = 0;
    int           n_err = 0;
    int           exp_faults = 0;
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    multi_fetch_stage #(.NUM_CH(NCH), .DEPTH(4), .DROP_FAULTS(0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_slave_valid(s_vld), .fetch_slave_ready(s_rdy), .fetch_slave_data(s_dat),
        .fetch_master_valid(m_vld), .fetch_master_ready(m_rdy),
        .fetch_master_data(m_dat), .fetch_master_id(m_id),
        .fetch_ctrl_flush(flush), .fetch_ctrl_stall(stall),
        .exception_cause_o(cause), .fault_count_o(fcnt)
    );

    multi_fetch_stage #(.NUM_CH(NCH), .DEPTH(4), .DROP_FAULTS(1)) dut_drop (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_slave_valid(s_vld), .fetch_slave_ready(d_s_rdy), .fetch_slave_data(s_dat),
        .fetch_master_valid(d_m_vld), .fetch_master_ready(m_rdy),
        .fetch_master_data(d_m_dat), .fetch_master_id(d_m_id),
        .fetch_ctrl_flush(flush), .fetch_ctrl_stall(stall),
        .exception_cause_o(d_cause), .fault_count_o(d_fcnt)
    );

    function automatic mptw_transaction_t mk(input logic [3:0] m, input logic [63:0] spa, input logic [15:0] tag);
        mptw_transaction_t t;
        t.mmpt.mode = m;
        t.mmpt.sdid = 12'hA5C;
        t.mmpt.ppn  = tag;
        t.spa       = spa;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input int ch, input mptw_transaction_t t, input page_format_fault_e c);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        s_vld[ch] = 1'b1;
        s_dat[ch*DW +: DW] = t;
        for (int n = 0; n < 100 && !ok; n++) begin
            #1;
            if (s_rdy[ch]) ok = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL send_timeout ch%0d: ready stayed 0, expected 1", ch);
        end else begin
            exp_q.push_back('{data: t, id: 3'(ch), cause: c});
            if (c != NO_ERROR) exp_faults++;
        end
        @(posedge clk);
        #1;
        s_vld[ch] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() > 0; n++) @(negedge clk);
        chk("drain_left", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin : mon
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && m_vld && m_rdy && !flush) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mon_unexpected: id %0d data %h, expected no output", m_id, m_dat);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_data", 128'(m_dat), 128'(e.data));
                    chk("mon_id", 128'(m_id), 128'(e.id));
                    chk("mon_cause", 128'(cause), 128'(e.cause));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_vld = '0; s_dat = '0; m_rdy = 1'b1; flush = 1'b0; stall = 1'b0;
        s_vld = 2'b11;
        s_dat[0 +: DW] = mk(SMMPT43_MODE, 64'h0, 16'h0EEE);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mvalid", 128'(m_vld), 128'(0));
        chk("rst_srdy", 128'(s_rdy), 128'(0));
        chk("rst_cause", 128'(cause), 128'(NO_ERROR));
        chk("rst_fcnt", 128'(fcnt), 128'(0));
        chk("rst_mdata", 128'(m_dat), 128'(0));
        chk("rst_mid", 128'(m_id), 128'(0));
        s_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single clean transaction: visible one cycle after acceptance.
        send(0, mk(SMMPT43_MODE, 64'h0000_0123_4567_89AB, 16'h0001), NO_ERROR);
        chk("lat1_valid", 128'(m_vld), 128'(1));
        chk("lat1_drop_valid", 128'(d_m_vld), 128'(1));

        // SMMPT52 with ZERO bit set: forwarded with cause here, dropped by the other instance.
        send(1, mk(SMMPT52_MODE, 64'h0010_0000_0000_1000, 16'h0002), NOT_VALID_ADDR);
        chk("fault_valid", 128'(m_vld), 128'(1));
        chk("fault_fcnt", 128'(fcnt), 128'(1));
        chk("drop_no_valid", 128'(d_m_vld), 128'(0));
        chk("drop_fcnt", 128'(d_fcnt), 128'(1));

        send(0, mk(BARE_MODE,    64'h0000_0000_0000_1000, 16'h0010), NOT_VALID_ADDR);
        send(1, mk(SMMPT64_MODE, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0011), NO_ERROR);
        send(0, mk(4'h7,         64'h0000_0000_0000_0000, 16'h0012), NOT_VALID_ADDR);
        send(1, mk(SMMPT43_MODE, 64'h0000_0800_0000_0000, 16'h0013), NOT_VALID_ADDR);
        send(0, mk(SMMPT52_MODE, 64'h000F_FFFF_FFFF_FFFF, 16'h0014), NO_ERROR);
        send(1, mk(SMMPT43_MODE, 64'h0000_07FF_FFFF_FFFF, 16'h0015), NO_ERROR);
        chk("fmt_fcnt", 128'(fcnt), 128'(4));
        drain();

        // Both channels valid continuously: grants alternate starting at channel 0.
        @(negedge clk);
        s_vld = 2'b11;
        s_dat[0 +: DW]  = mk(SMMPT64_MODE, 64'h1, 16'h0100);
        s_dat[DW +: DW] = mk(SMMPT64_MODE, 64'h2, 16'h0200);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 128'(s_rdy), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
            exp_q.push_back('{data: s_dat[(k%2)*DW +: DW], id: 3'(k % 2), cause: NO_ERROR});
            @(posedge clk);
            #1;
            s_dat[(k%2)*DW +: DW] = mk(SMMPT64_MODE, 64'h3, 16'(16'h0300 + k));
            @(negedge clk);
        end
        s_vld = '0;
        drain();

        // Fill with the master stalled: the fifth request waits until a pop has happened.
        m_rdy = 1'b0;
        for (int k = 0; k < 4; k++) send(0, mk(SMMPT64_MODE, 64'h4, 16'(16'h0400 + k)), NO_ERROR);
        @(negedge clk);
        s_vld[0] = 1'b1;
        s_dat[0 +: DW] = mk(SMMPT64_MODE, 64'h4, 16'h0404);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("full_block", 128'(s_rdy[0]), 128'(0));
            @(negedge clk);
        end
        m_rdy = 1'b1;
        #1;
        chk("full_pop_block", 128'(s_rdy[0]), 128'(0));
        @(negedge clk);
        m_rdy = 1'b0;
        #1;
        chk("full_after_pop", 128'(s_rdy[0]), 128'(1));
        exp_q.push_back('{data: s_dat[0 +: DW], id: 3'(0), cause: NO_ERROR});
        @(posedge clk);
        #1;
        s_vld[0] = 1'b0;
        m_rdy = 1'b1;
        drain();

        // Flush three buffered entries; arbitration pointer must survive the flush.
        m_rdy = 1'b0;
        send(0, mk(SMMPT64_MODE, 64'h5, 16'h0500), NO_ERROR);
        send(1, mk(SMMPT64_MODE, 64'h5, 16'h0501), NO_ERROR);
        send(0, mk(SMMPT64_MODE, 64'h5, 16'h0502), NO_ERROR);
        @(negedge clk);
        flush = 1'b1;
        m_rdy = 1'b1;
        s_vld = 2'b11;
        s_dat[0 +: DW]  = mk(SMMPT64_MODE, 64'h6, 16'h0600);
        s_dat[DW +: DW] = mk(SMMPT64_MODE, 64'h6, 16'h0601);
        #1;
        chk("flush_no_accept", 128'(s_rdy), 128'(0));
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_empty", 128'(m_vld), 128'(0));
        chk("flush_rr", 128'(s_rdy), 128'(2'b10));
        chk("flush_fcnt", 128'(fcnt), 128'(exp_faults));
        exp_q.push_back('{data: s_dat[DW +: DW], id: 3'(1), cause: NO_ERROR});
        @(posedge clk);
        #1;
        s_vld = '0;
        drain();

        // Stall blocks acceptance but the master side keeps draining.
        m_rdy = 1'b0;
        send(0, mk(SMMPT64_MODE, 64'h7, 16'h0700), NO_ERROR);
        send(1, mk(SMMPT64_MODE, 64'h7, 16'h0701), NO_ERROR);
        @(negedge clk);
        stall = 1'b1;
        m_rdy = 1'b1;
        s_vld[0] = 1'b1;
        s_dat[0 +: DW] = mk(SMMPT64_MODE, 64'h7, 16'h0702);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_block", 128'(s_rdy[0]), 128'(0));
            @(negedge clk);
        end
        #1;
        chk("stall_drained", 128'(m_vld), 128'(0));
        stall = 1'b0;
        #1;
        chk("stall_release", 128'(s_rdy), 128'(2'b01));
        exp_q.push_back('{data: s_dat[0 +: DW], id: 3'(0), cause: NO_ERROR});
        @(posedge clk);
        #1;
        s_vld = '0;
        drain();

        // Reset while two entries are buffered.
        m_rdy = 1'b0;
        send(0, mk(SMMPT64_MODE, 64'h8, 16'h0800), NO_ERROR);
        send(1, mk(SMMPT52_MODE, 64'h0020_0000_0000_0000, 16'h0801), NOT_VALID_ADDR);
        @(negedge clk);
        s_vld = 2'b11;
        s_dat[0 +: DW]  = mk(SMMPT64_MODE, 64'h9, 16'h0900);
        s_dat[DW +: DW] = mk(SMMPT64_MODE, 64'h9, 16'h0901);
        rst_n = 1'b0;
        #1;
        chk("mrst_mvalid", 128'(m_vld), 128'(0));
        chk("mrst_mdata", 128'(m_dat), 128'(0));
        chk("mrst_mid", 128'(m_id), 128'(0));
        chk("mrst_cause", 128'(cause), 128'(NO_ERROR));
        chk("mrst_fcnt", 128'(fcnt), 128'(0));
        chk("mrst_srdy", 128'(s_rdy), 128'(0));
        exp_q.delete();
        exp_faults = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("mrst_empty", 128'(m_vld), 128'(0));
        chk("mrst_rr", 128'(s_rdy), 128'(2'b01));
        exp_q.push_back('{data: s_dat[0 +: DW], id: 3'(0), cause: NO_ERROR});
        m_rdy = 1'b1;
        @(posedge clk);
        #1;
        s_vld = '0;
        drain();
        chk("end_fcnt", 128'(fcnt), 128'(exp_faults));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
